// File: rtl/signed_overflow_accum.sv
// Signed add/subtract/accumulate unit with overflow detection, optional saturation,
// a one-deep valid/ready output register, and sticky/counted overflow status.
module signed_overflow_accum #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             overflow,
  output logic [WIDTH-1:0] acc,
  output logic             ovf_sticky,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_e;

  state_e           state, state_next;
  logic             accept;
  logic             transfer;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] res;
  logic             ovf_det;
  logic             x_sign;

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign transfer  = out_valid && out_ready;

  // NOTE: every signal assigned in this block gets a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    raw     = '0;
    ovf_det = 1'b0;
    x_sign  = a[MSB];
    unique case (op_e'(op))
      OP_ADD: begin
        raw     = a + b;
        ovf_det = (a[MSB] == b[MSB]) && (raw[MSB] != a[MSB]);
      end
      OP_SUB: begin
        raw     = a - b;
        ovf_det = (a[MSB] != b[MSB]) && (raw[MSB] != a[MSB]);
      end
      OP_ACC: begin
        raw     = acc + a;
        x_sign  = acc[MSB];
        ovf_det = (acc[MSB] == a[MSB]) && (raw[MSB] != acc[MSB]);
      end
      OP_LOAD: begin
        raw = a;
      end
    endcase
    // Saturation direction follows the sign of the first operand, which is
    // the sign every overflowing result should have had.
    res = raw;
    if (sat_en && ovf_det) res = x_sign ? MIN_NEG : MAX_POS;
  end

  always_comb begin
    state_next = state;
    if (accept)        state_next = FULL;
    else if (transfer) state_next = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s        <= '0;
      overflow <= 1'b0;
      acc      <= '0;
    end else if (accept) begin
      s        <= res;
      overflow <= ovf_det;
      if (op_e'(op) == OP_ACC || op_e'(op) == OP_LOAD) acc <= res;
    end
  end

  // A new overflow event in the same cycle as a clear counts as the first event.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (accept && ovf_det) begin
      ovf_sticky <= 1'b1;
      if (ovf_clr)         ovf_count <= CNT_W'(1);
      else if (!(&ovf_count)) ovf_count <= ovf_count + CNT_W'(1);
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end
  end

endmodule

// File: tb/tb_signed_overflow_accum.sv
// Lockstep bench: directed test-plan sequences plus random traffic, compared
// cycle by cycle against an integer-arithmetic reference model.
module tb_signed_overflow_accum;

  localparam int W  = 8;
  localparam int CW = 2;
  localparam int SMAX = (2 ** (W - 1)) - 1;
  localparam int SMIN = -(2 ** (W - 1));
  localparam int CMAX = (2 ** CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [1:0]    op;
  logic          sat_en;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  s;
  logic          overflow;
  logic [W-1:0]  acc;
  logic          ovf_sticky;
  logic          ovf_clr;
  logic [CW-1:0] ovf_count;

  int checks   = 0;
  int failures = 0;

  logic         m_valid;
  logic [W-1:0] m_s;
  logic         m_ovf;
  logic [W-1:0] m_acc;
  logic         m_sticky;
  int           m_count;

  signed_overflow_accum #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .sat_en(sat_en), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .overflow(overflow), .acc(acc),
    .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: exact integer result, then clamp or wrap into W bits.
  function automatic void model_op(input logic [1:0] o, input logic [W-1:0] cur_acc,
                                   input logic [W-1:0] ia, input logic [W-1:0] ib,
                                   input logic sat, output logic [W-1:0] res,
                                   output logic ov);
    int av, bv, cv, full;
    av = $signed(ia);
    bv = $signed(ib);
    cv = $signed(cur_acc);
    case (o)
      2'b00:   full = av + bv;
      2'b01:   full = av - bv;
      2'b10:   full = cv + av;
      default: full = av;
    endcase
    ov = (full > SMAX) || (full < SMIN);
    if (ov && sat) res = (full > SMAX) ? W'(SMAX) : W'(SMIN);
    else           res = full[W-1:0];
  endfunction

  task automatic step();
    logic         exp_ready, acc_now, xfer, ov;
    logic [W-1:0] res;
    #1;
    exp_ready = !m_valid || out_ready;
    check("in_ready", in_ready, exp_ready);
    acc_now = in_valid && exp_ready;
    xfer    = m_valid && out_ready;
    model_op(op, m_acc, a, b, sat_en, res, ov);
    @(posedge clk);
    #1;
    if (reset) begin
      m_valid = 0; m_s = '0; m_ovf = 0; m_acc = '0; m_sticky = 0; m_count = 0;
    end else begin
      if (acc_now) begin
        m_valid = 1;
        m_s     = res;
        m_ovf   = ov;
        if (op[1]) m_acc = res;
      end else if (xfer) begin
        m_valid = 0;
      end
      if (acc_now && ov) begin
        m_sticky = 1;
        m_count  = ovf_clr ? 1 : ((m_count < CMAX) ? m_count + 1 : CMAX);
      end else if (ovf_clr) begin
        m_sticky = 0;
        m_count  = 0;
      end
    end
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("s", s, m_s);
      check("overflow", overflow, m_ovf);
    end
    check("acc", acc, m_acc);
    check("ovf_sticky", ovf_sticky, m_sticky);
    check("ovf_count", ovf_count, m_count);
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] ia,
                       input logic [W-1:0] ib, input logic sat);
    in_valid = 1; op = o; a = ia; b = ib; sat_en = sat;
    step();
    in_valid = 0;
  endtask

  initial begin
    reset = 1; in_valid = 0; a = '0; b = '0; op = '0; sat_en = 0;
    out_ready = 1; ovf_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    m_valid = 0; m_s = '0; m_ovf = 0; m_acc = '0; m_sticky = 0; m_count = 0;
    check("rst_out_valid", out_valid, 0);
    check("rst_s", s, 0);
    check("rst_acc", acc, 0);
    check("rst_count", ovf_count, 0);
    reset = 0;
    check("rst_in_ready", in_ready, 1);

    // Wrapping add
    issue(2'b00, 8'h90, 8'h90, 0); check("t1_s0", s, 8'h20); check("t1_o0", overflow, 1);
    issue(2'b00, 8'h70, 8'h70, 0); check("t1_s1", s, 8'hE0); check("t1_o1", overflow, 1);
    issue(2'b00, 8'h12, 8'h56, 0); check("t1_s2", s, 8'h68); check("t1_o2", overflow, 0);

    // Saturating add/sub
    issue(2'b00, 8'h90, 8'h90, 1); check("t2_s0", s, 8'h80);
    issue(2'b00, 8'h70, 8'h70, 1); check("t2_s1", s, 8'h7F);
    issue(2'b01, 8'h80, 8'h01, 1); check("t2_s2", s, 8'h80); check("t2_o2", overflow, 1);
    issue(2'b01, 8'h00, 8'h80, 1); check("t2_s3", s, 8'h7F); check("t2_o3", overflow, 1);
    issue(2'b01, 8'h00, 8'h80, 0); check("t2_s4", s, 8'h80); check("t2_o4", overflow, 1);

    // Accumulate with saturation
    issue(2'b11, 8'h40, 8'h00, 1); check("t3_acc0", acc, 8'h40);
    issue(2'b10, 8'h40, 8'h00, 1); check("t3_acc1", acc, 8'h7F); check("t3_o1", overflow, 1);
    issue(2'b10, 8'h01, 8'h00, 1); check("t3_acc2", acc, 8'h7F); check("t3_o2", overflow, 1);
    issue(2'b10, 8'hFF, 8'h00, 1); check("t3_acc3", acc, 8'h7E); check("t3_o3", overflow, 0);
    issue(2'b00, 8'h05, 8'h05, 1); check("t3_acc4", acc, 8'h7E); check("t3_s4", s, 8'h0A);

    // Backpressure: result held while the consumer stalls
    issue(2'b00, 8'h11, 8'h22, 0);
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; op = 2'b11; a = 8'(i + 1); b = '0;
      step();
      check("t4_hold_s", s, 8'h33);
      check("t4_hold_rdy", in_ready, 0);
    end
    out_ready = 1;
    in_valid = 1; op = 2'b00; a = 8'h01; b = 8'h02;
    step();
    in_valid = 0;
    check("t4_valid_kept", out_valid, 1);
    check("t4_new_s", s, 8'h03);
    step();

    // Status counter saturation and clear
    ovf_clr = 1; step(); ovf_clr = 0;
    for (int i = 0; i < 5; i++) issue(2'b00, 8'h70, 8'h70, 0);
    check("t5_cnt_sat", ovf_count, 3); check("t5_sticky", ovf_sticky, 1);
    ovf_clr = 1; step();
    check("t5_cnt_clr", ovf_count, 0); check("t5_sticky_clr", ovf_sticky, 0);
    issue(2'b00, 8'h90, 8'h90, 0); ovf_clr = 0;
    check("t5_cnt_both", ovf_count, 1); check("t5_sticky_both", ovf_sticky, 1);

    // Reset while a result is stalled
    ovf_clr = 1; issue(2'b11, 8'h55, 8'h00, 0); ovf_clr = 0;
    issue(2'b00, 8'h70, 8'h70, 0);
    issue(2'b00, 8'h70, 8'h70, 0);
    out_ready = 0; step();
    check("t6_pre_acc", acc, 8'h55); check("t6_pre_cnt", ovf_count, 2);
    reset = 1; step(); reset = 0;
    check("t6_valid", out_valid, 0); check("t6_s", s, 0); check("t6_ovf", overflow, 0);
    check("t6_acc", acc, 0); check("t6_sticky", ovf_sticky, 0); check("t6_cnt", ovf_count, 0);
    #1 check("t6_in_ready", in_ready, 1);
    out_ready = 1;
    repeat (3) step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op        = 2'($urandom_range(0, 3));
      a         = 8'($urandom);
      b         = 8'($urandom);
      sat_en    = 1'($urandom);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 63) == 0);
      step();
    end
    reset = 0; in_valid = 0; ovf_clr = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
